// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of data_mem. It accepts byte-addressed RISC-V
// loads and stores, splits accesses that cross a word boundary into two word
// accesses, and returns a one-cycle response pulse.
module lsu_mem_ctrl #(
  parameter int unsigned WORD_AW  = 5,
  parameter bit          SPLIT_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [WORD_AW+1:0]   req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 resp_valid,
  output logic [31:0]          resp_data,
  output logic                 resp_err,
  output logic                 mem_wren,
  output logic                 mem_is_load,
  output logic [3:0]           mem_mask,
  output logic [WORD_AW-1:0]   mem_r_addr,
  output logic [WORD_AW-1:0]   mem_w_addr,
  output logic [31:0]          mem_w_data,
  input  logic [31:0]          mem_r_data
);

  typedef enum logic [1:0] {StIdle, StMem0, StMem1, StCap} state_e;

  state_e              state_q, state_d;
  logic                we_q;
  logic [2:0]          f3_q;
  logic [WORD_AW+1:0]  addr_q;
  logic [31:0]         wdata_q;
  logic                err_q;
  logic                split_q;
  logic [31:0]         lo_q;
  logic                resp_valid_q;
  logic                resp_err_q;
  logic [31:0]         resp_data_q;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return f3 inside {3'b000, 3'b001, 3'b010};
    return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  endfunction

  // True when the access runs past byte 3 of its first word.
  function automatic logic is_split(input logic [2:0] f3, input logic [1:0] off);
    logic [2:0] n;
    logic [3:0] end_b;
    unique case (f3[1:0])
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      default: n = 3'd4;
    endcase
    end_b = {2'b00, off} + {1'b0, n};
    return end_b > 4'd4;
  endfunction

  logic                req_err;
  logic                req_split;
  logic [WORD_AW-1:0]  w0, w1;
  logic [1:0]          off;
  logic [3:0]          base_mask;
  logic [7:0]          mask8;
  logic [63:0]         wdata64;
  logic [31:0]         ld_lo, ld_hi, ld_word, ld_result;

  assign req_split = is_split(req_funct3, req_addr[1:0]);
  assign req_err   = !f3_legal(req_we, req_funct3) || (req_split && !SPLIT_EN);

  assign off = addr_q[1:0];
  assign w0  = addr_q[WORD_AW+1:2];
  assign w1  = w0 + WORD_AW'(1);  // wraps from the top word to word 0

  // Byte mask and lane-shifted store data spanning both words.
  always_comb begin
    unique case (f3_q[1:0])
      2'b00:   base_mask = 4'b0001;
      2'b01:   base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase
    mask8   = {4'b0000, base_mask} << off;
    wdata64 = {32'h0, wdata_q} << {off, 3'b000};
  end

  // Load data: word0 comes from lo_q on split accesses, word1 arrives in CAP.
  always_comb begin
    ld_lo   = split_q ? lo_q : mem_r_data;
    ld_hi   = split_q ? mem_r_data : 32'h0;
    ld_word = 32'({ld_hi, ld_lo} >> {off, 3'b000});
    unique case (f3_q)
      3'b000:  ld_result = {{24{ld_word[7]}}, ld_word[7:0]};
      3'b001:  ld_result = {{16{ld_word[15]}}, ld_word[15:0]};
      3'b100:  ld_result = {24'h0, ld_word[7:0]};
      3'b101:  ld_result = {16'h0, ld_word[15:0]};
      default: ld_result = ld_word;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next state and data_mem drive; mem_* are 0 outside MEM0/MEM1.
  always_comb begin
    state_d     = state_q;
    mem_wren    = 1'b0;
    mem_is_load = 1'b0;
    mem_mask    = 4'b0000;
    mem_r_addr  = '0;
    mem_w_addr  = '0;
    mem_w_data  = 32'h0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) state_d = req_err ? StCap : StMem0;
      end
      StMem0: begin
        if (we_q) begin
          mem_wren   = 1'b1;
          mem_w_addr = w0;
          mem_mask   = mask8[3:0];
          mem_w_data = wdata64[31:0];
        end else begin
          mem_is_load = 1'b1;
          mem_r_addr  = w0;
        end
        state_d = split_q ? StMem1 : StCap;
      end
      StMem1: begin
        if (we_q) begin
          mem_wren   = 1'b1;
          mem_w_addr = w1;
          mem_mask   = mask8[7:4];
          mem_w_data = wdata64[63:32];
        end else begin
          mem_is_load = 1'b1;
          mem_r_addr  = w1;
        end
        state_d = StCap;
      end
      StCap: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request latch, word0 capture and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q         <= 1'b0;
      f3_q         <= 3'b000;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      err_q        <= 1'b0;
      split_q      <= 1'b0;
      lo_q         <= 32'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= 32'h0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= 32'h0;
      if (state_q == StIdle && req_valid) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        err_q   <= req_err;
        split_q <= req_split;
      end
      if (state_q == StMem1) lo_q <= mem_r_data;
      if (state_q == StCap) begin
        resp_valid_q <= 1'b1;
        resp_err_q   <= err_q;
        resp_data_q  <= (err_q || we_q) ? 32'h0 : ld_result;
      end
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: a behavioural data_mem model, a table of directed
// requests with hand-computed results, plus reset and no-split sequences.
module tb_lsu_mem_ctrl;

  localparam int unsigned WORD_AW = 5;
  localparam int unsigned AW      = WORD_AW + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              req_valid_m = 1'b0;
  logic              sel_ns = 1'b0;
  logic              req_we = 1'b0;
  logic [2:0]        req_funct3 = 3'b000;
  logic [AW-1:0]     req_addr = '0;
  logic [31:0]       req_wdata = 32'h0;

  // Main instance (SPLIT_EN=1)
  logic              req_valid, req_ready, resp_valid, resp_err;
  logic [31:0]       resp_data, mem_w_data, mem_r_data;
  logic              mem_wren, mem_is_load;
  logic [3:0]        mem_mask;
  logic [WORD_AW-1:0] mem_r_addr, mem_w_addr;

  // No-split instance (SPLIT_EN=0)
  logic              ns_req_valid, ns_req_ready, ns_resp_valid, ns_resp_err;
  logic [31:0]       ns_resp_data, ns_mem_w_data;
  logic [31:0]       ns_mem_r_data = 32'h0;
  logic              ns_mem_wren, ns_mem_is_load;
  logic [3:0]        ns_mem_mask;
  logic [WORD_AW-1:0] ns_mem_r_addr, ns_mem_w_addr;

  assign req_valid    = req_valid_m && !sel_ns;
  assign ns_req_valid = req_valid_m && sel_ns;

  lsu_mem_ctrl #(.WORD_AW(WORD_AW), .SPLIT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .mem_wren(mem_wren), .mem_is_load(mem_is_load), .mem_mask(mem_mask),
    .mem_r_addr(mem_r_addr), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
    .mem_r_data(mem_r_data)
  );

  lsu_mem_ctrl #(.WORD_AW(WORD_AW), .SPLIT_EN(1'b0)) dut_ns (
    .clk(clk), .rst(rst), .req_valid(ns_req_valid), .req_ready(ns_req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(ns_resp_valid), .resp_data(ns_resp_data), .resp_err(ns_resp_err),
    .mem_wren(ns_mem_wren), .mem_is_load(ns_mem_is_load), .mem_mask(ns_mem_mask),
    .mem_r_addr(ns_mem_r_addr), .mem_w_addr(ns_mem_w_addr), .mem_w_data(ns_mem_w_data),
    .mem_r_data(ns_mem_r_data)
  );

  // data_mem model: byte-masked write, registered read.
  logic [31:0] mem [32];
  logic        mem_clr = 1'b1;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
    end else if (mem_wren) begin
      for (int b = 0; b < 4; b++)
        if (mem_mask[b]) mem[mem_w_addr][8*b +: 8] <= mem_w_data[8*b +: 8];
    end
    mem_r_data <= mem[mem_r_addr];
  end

  // Selected-instance view used by the request task
  logic s_ready, s_resp_valid, s_resp_err, s_wren, s_is_load;
  logic [31:0] s_resp_data, s_w_data;
  logic [3:0]  s_mask;
  logic [WORD_AW-1:0] s_r_addr, s_w_addr;
  always_comb begin
    s_ready      = sel_ns ? ns_req_ready   : req_ready;
    s_resp_valid = sel_ns ? ns_resp_valid  : resp_valid;
    s_resp_err   = sel_ns ? ns_resp_err    : resp_err;
    s_resp_data  = sel_ns ? ns_resp_data   : resp_data;
    s_wren       = sel_ns ? ns_mem_wren    : mem_wren;
    s_is_load    = sel_ns ? ns_mem_is_load : mem_is_load;
    s_mask       = sel_ns ? ns_mem_mask    : mem_mask;
    s_r_addr     = sel_ns ? ns_mem_r_addr  : mem_r_addr;
    s_w_addr     = sel_ns ? ns_mem_w_addr  : mem_w_addr;
    s_w_data     = sel_ns ? ns_mem_w_data  : mem_w_data;
  end

  logic both_seen = 1'b0;
  always @(negedge clk)
    if ((mem_wren && mem_is_load) || (ns_mem_wren && ns_mem_is_load)) both_seen <= 1'b1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Per-cycle log of memory activity during one request
  int          nlog;
  logic        lg_we   [4];
  logic [4:0]  lg_addr [4];
  logic [3:0]  lg_mask [4];
  logic [31:0] lg_data [4];

  // Called at a negedge; returns at the negedge where the response is seen.
  task automatic run_req(input logic ns, input logic we, input logic [2:0] f3,
                         input logic [AW-1:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic rerr, output int lat);
    bit got = 0;
    sel_ns = ns; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    req_valid_m = 1'b1;
    #1;
    chk("ready_at_req", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1 req_valid_m = 1'b0;
    nlog = 0; lat = 0; rdata = 32'h0; rerr = 1'b0;
    for (int c = 1; c <= 12 && !got; c++) begin
      @(negedge clk);
      if (s_wren || s_is_load) begin
        if (nlog < 4) begin
          lg_we[nlog]   = s_wren;
          lg_addr[nlog] = s_wren ? s_w_addr : s_r_addr;
          lg_mask[nlog] = s_mask;
          lg_data[nlog] = s_w_data;
        end
        nlog++;
      end
      if (s_resp_valid) begin
        got = 1; lat = c; rdata = s_resp_data; rerr = s_resp_err;
        chk("ready_in_resp", 32'(s_ready), 32'd1);
      end
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL resp_timeout: got no resp_valid, expected one within 12 cycles");
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [31:0] edata;
    logic        eerr;
    int          elat;
    int          nacc;
    logic [4:0]  a0; logic [3:0] m0; logic [31:0] d0;
    logic [4:0]  a1; logic [3:0] m1; logic [31:0] d1;
  } vec_t;

  vec_t vt [19];

  initial begin
    logic [31:0] rd;
    logic        re;
    int          lt;
    bit          rv_seen;

    // we f3 addr wdata | edata eerr elat nacc | a0 m0 d0 | a1 m1 d1
    vt[0]  = '{1, 3'b010, 7'h08, 32'hDEADBEEF, 32'h0,        0, 3, 1, 2,  4'hF, 32'hDEADBEEF, 0, 4'h0, 32'h0};
    vt[1]  = '{0, 3'b010, 7'h08, 32'h0,        32'hDEADBEEF, 0, 3, 1, 2,  4'h0, 32'h0,        0, 4'h0, 32'h0};
    vt[2]  = '{0, 3'b000, 7'h0B, 32'h0,        32'hFFFFFFDE, 0, 3, 1, 2,  4'h0, 32'h0,        0, 4'h0, 32'h0};
    vt[3]  = '{0, 3'b100, 7'h0B, 32'h0,        32'h000000DE, 0, 3, 1, 2,  4'h0, 32'h0,        0, 4'h0, 32'h0};
    vt[4]  = '{0, 3'b001, 7'h0A, 32'h0,        32'hFFFFDEAD, 0, 3, 1, 2,  4'h0, 32'h0,        0, 4'h0, 32'h0};
    vt[5]  = '{0, 3'b101, 7'h08, 32'h0,        32'h0000BEEF, 0, 3, 1, 2,  4'h0, 32'h0,        0, 4'h0, 32'h0};
    vt[6]  = '{1, 3'b010, 7'h0E, 32'h11223344, 32'h0,        0, 4, 2, 3,  4'hC, 32'h33440000, 4, 4'h3, 32'h00001122};
    vt[7]  = '{0, 3'b010, 7'h0E, 32'h0,        32'h11223344, 0, 4, 2, 3,  4'h0, 32'h0,        4, 4'h0, 32'h0};
    vt[8]  = '{1, 3'b001, 7'h7F, 32'h0000ABCD, 32'h0,        0, 4, 2, 31, 4'h8, 32'hCD000000, 0, 4'h1, 32'h000000AB};
    vt[9]  = '{0, 3'b101, 7'h7F, 32'h0,        32'h0000ABCD, 0, 4, 2, 31, 4'h0, 32'h0,        0, 4'h0, 32'h0};
    vt[10] = '{0, 3'b010, 7'h7D, 32'h0,        32'hABCD0000, 0, 4, 2, 31, 4'h0, 32'h0,        0, 4'h0, 32'h0};
    vt[11] = '{0, 3'b001, 7'h0F, 32'h0,        32'h00002233, 0, 4, 2, 3,  4'h0, 32'h0,        4, 4'h0, 32'h0};
    vt[12] = '{1, 3'b000, 7'h05, 32'h123456FF, 32'h0,        0, 3, 1, 1,  4'h2, 32'h3456FF00, 0, 4'h0, 32'h0};
    vt[13] = '{0, 3'b000, 7'h05, 32'h0,        32'hFFFFFFFF, 0, 3, 1, 1,  4'h0, 32'h0,        0, 4'h0, 32'h0};
    vt[14] = '{0, 3'b100, 7'h05, 32'h0,        32'h000000FF, 0, 3, 1, 1,  4'h0, 32'h0,        0, 4'h0, 32'h0};
    vt[15] = '{0, 3'b011, 7'h00, 32'h0,        32'h0,        1, 2, 0, 0,  4'h0, 32'h0,        0, 4'h0, 32'h0};
    vt[16] = '{1, 3'b100, 7'h04, 32'h00000055, 32'h0,        1, 2, 0, 0,  4'h0, 32'h0,        0, 4'h0, 32'h0};
    vt[17] = '{0, 3'b110, 7'h10, 32'h0,        32'h0,        1, 2, 0, 0,  4'h0, 32'h0,        0, 4'h0, 32'h0};
    vt[18] = '{0, 3'b000, 7'h0E, 32'h0,        32'h00000044, 0, 3, 1, 3,  4'h0, 32'h0,        0, 4'h0, 32'h0};

    // Reset state
    #2;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err",   32'(resp_err),   32'd0);
    chk("rst_resp_data",  resp_data,       32'h0);
    chk("rst_mem_ctl",    {28'h0, mem_wren, mem_is_load, 2'b00}, 32'h0);
    chk("rst_mem_mask",   32'(mem_mask),   32'h0);
    chk("rst_mem_wdata",  mem_w_data,      32'h0);
    @(negedge clk); @(negedge clk);
    mem_clr = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 19; i++) begin
      run_req(1'b0, vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, rd, re, lt);
      chk($sformatf("v%0d_data", i), rd, vt[i].edata);
      chk($sformatf("v%0d_err", i), 32'(re), 32'(vt[i].eerr));
      chk($sformatf("v%0d_lat", i), 32'(lt), 32'(vt[i].elat));
      chk($sformatf("v%0d_nacc", i), 32'(nlog), 32'(vt[i].nacc));
      for (int k = 0; k < vt[i].nacc && k < nlog && k < 2; k++) begin
        chk($sformatf("v%0d_c%0d_we", i, k), 32'(lg_we[k]), 32'(vt[i].we));
        chk($sformatf("v%0d_c%0d_addr", i, k), 32'(lg_addr[k]),
            32'(k == 0 ? vt[i].a0 : vt[i].a1));
        chk($sformatf("v%0d_c%0d_mask", i, k), 32'(lg_mask[k]),
            32'(k == 0 ? vt[i].m0 : vt[i].m1));
        if (vt[i].we)
          chk($sformatf("v%0d_c%0d_wdata", i, k), lg_data[k], k == 0 ? vt[i].d0 : vt[i].d1);
      end
    end

    // No-split instance: misaligned SH is an error with no memory activity
    run_req(1'b1, 1'b1, 3'b001, 7'h7F, 32'h0000ABCD, rd, re, lt);
    chk("ns_split_err",  32'(re),   32'd1);
    chk("ns_split_data", rd,        32'h0);
    chk("ns_split_lat",  32'(lt),   32'd2);
    chk("ns_split_nacc", 32'(nlog), 32'd0);
    run_req(1'b1, 1'b1, 3'b010, 7'h08, 32'h12345678, rd, re, lt);
    chk("ns_align_err",  32'(re),   32'd0);
    chk("ns_align_lat",  32'(lt),   32'd3);
    chk("ns_align_nacc", 32'(nlog), 32'd1);
    sel_ns = 1'b0;

    // Reset during MEM1 of a split store: word 3 already written, word 4 kept
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 7'h0E; req_wdata = 32'hCAFEF00D;
    req_valid_m = 1'b1;
    @(posedge clk);
    #1 req_valid_m = 1'b0;
    @(negedge clk);
    chk("rm_mem0_waddr", 32'(mem_w_addr), 32'd3);
    @(negedge clk);
    chk("rm_mem1_wren",  32'(mem_wren),   32'd1);
    chk("rm_mem1_waddr", 32'(mem_w_addr), 32'd4);
    #1 rst = 1'b1;
    #1;
    chk("rm_wren",  32'(mem_wren),   32'd0);
    chk("rm_mask",  32'(mem_mask),   32'd0);
    chk("rm_waddr", 32'(mem_w_addr), 32'd0);
    chk("rm_wdata", mem_w_data,      32'h0);
    rv_seen = 0;
    @(negedge clk);
    rst = 1'b0;
    chk("rm_word3", mem[3], 32'hF00D0000);
    chk("rm_word4", mem[4], 32'h00001122);
    #1;
    chk("rm_ready", 32'(req_ready), 32'd1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (resp_valid) rv_seen = 1;
    end
    chk("rm_no_resp", 32'(rv_seen), 32'd0);

    // Back-to-back: second request issued in the resp_valid cycle of the first
    run_req(1'b0, 1'b0, 3'b010, 7'h08, 32'h0, rd, re, lt);
    chk("b2b_a_data", rd, 32'hDEADBEEF);
    run_req(1'b0, 1'b0, 3'b001, 7'h0A, 32'h0, rd, re, lt);
    chk("b2b_b_data", rd, 32'hFFFFDEAD);
    chk("b2b_b_lat",  32'(lt), 32'd3);

    chk("never_wren_and_load", 32'(both_seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation time limit, expected test completion");
    $fatal(1, "watchdog");
  end

endmodule
